// File: rtl/ahb_subordinate_mem.sv
// AHB subordinate backed by a word-organised SRAM array.
// Supports programmable and external wait states, byte-lane writes and the two-cycle ERROR response.
module ahb_subordinate_mem #(
    parameter int DATA_WDT    = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                i_hclk,
    input  logic                i_hreset_n,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_wait,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hready,
    output logic [1:0]          o_hresp
);
    localparam int NB    = DATA_WDT / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'(NB);
    localparam logic [1:0]  HRESP_OKAY  = 2'd0;
    localparam logic [1:0]  HRESP_ERROR = 2'd1;

    typedef enum logic [1:0] {IDLE_ST, DATA_ST, ERR1_ST, ERR2_ST} state_t;

    state_t              r_state, w_next_state;
    logic [3:0]          r_cnt, w_next_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [OFF_W-1:0]    r_off;
    logic [2:0]          r_size;
    logic                r_write;
    logic [DATA_WDT-1:0] r_hrdata;
    logic [DATA_WDT-1:0] r_mem [MEM_DEPTH];

    logic                w_hready;
    logic [1:0]          w_hresp;
    logic                w_capture;
    logic                w_illegal;
    logic [7:0]          w_amask;
    logic                w_commit;
    logic [NB-1:0]       w_lane_en;
    logic                w_unused;

    // Burst type is irrelevant: every beat is decoded on its own.
    assign w_unused = ^i_hburst;

    assign w_amask   = (8'd1 << i_hsize) - 8'd1;
    assign w_illegal = ({1'b0, i_haddr} >= MEM_BYTES) ||
                       (i_hsize > 3'(OFF_W)) ||
                       (|(i_haddr[7:0] & w_amask));

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        case (r_state)
            DATA_ST: w_hready = (r_cnt == 4'd0) && !i_wait;
            ERR1_ST: begin
                w_hready = 1'b0;
                w_hresp  = HRESP_ERROR;
            end
            ERR2_ST: w_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    assign w_capture = w_hready && i_hsel && i_htrans[1];
    assign w_commit  = (r_state == DATA_ST) && w_hready && r_write;

    always_comb begin
        w_next_state = IDLE_ST;
        w_next_cnt   = r_cnt;
        if (r_state == DATA_ST && r_cnt != 4'd0)
            w_next_cnt = r_cnt - 4'd1;
        if (w_capture) begin
            w_next_state = w_illegal ? ERR1_ST : DATA_ST;
            w_next_cnt   = w_illegal ? 4'd0 : 4'(WAIT_STATES);
        end else if (r_state == ERR1_ST) begin
            w_next_state = ERR2_ST;
        end else if (r_state == DATA_ST && !w_hready) begin
            w_next_state = DATA_ST;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (!i_hreset_n) begin
            r_state  <= IDLE_ST;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_off    <= '0;
            r_size   <= 3'd0;
            r_write  <= 1'b0;
            r_hrdata <= '0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_hrdata <= o_hrdata;
            if (w_capture) begin
                r_idx   <= i_haddr[OFF_W +: IDX_W];
                r_off   <= i_haddr[OFF_W-1:0];
                r_size  <= i_hsize;
                r_write <= i_hwrite;
            end
        end
    end

    always_comb begin
        w_lane_en = '0;
        for (int b = 0; b < NB; b++)
            if (b >= int'(r_off) && b < int'(r_off) + (1 << r_size))
                w_lane_en[b] = 1'b1;
    end

    // Reset on the completion edge discards the beat.
    always_ff @(posedge i_hclk) begin
        if (i_hreset_n && w_commit)
            for (int b = 0; b < NB; b++)
                if (w_lane_en[b])
                    r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
    end

    assign o_hrdata = (r_state == DATA_ST && w_hready) ? r_mem[r_idx] : r_hrdata;
    assign o_hready = w_hready;
    assign o_hresp  = w_hresp;
endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Bench for ahb_subordinate_mem: three instances (0/2/3 wait states) share one bus, selected by hsel.
// Directed table, hand sequences for wait/reset corners, and randomized traffic against a byte-level memory model.
module tb_ahb_subordinate_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [31:0] hwdata = '0;
    logic        hwait = 1'b0;
    int          dsel = 0;
    bit          wait_en = 0;

    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic [1:0]  resp  [3];

    int total = 0;
    int bad   = 0;
    int ws_of [3] = '{0, 2, 3};
    logic [31:0] mm [3][256];

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        bit          wr;
        logic [31:0] wdata;
        int          chk;    // 0 none, 1 table constant, 2 model
        logic [31:0] exp;
    } beat_t;

    beat_t bq[$];
    beat_t tbl[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        ahb_subordinate_mem #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_STATES(WS)) u_dut (
            .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel && (dsel == g)),
            .i_haddr(haddr), .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize),
            .i_hburst(hburst), .i_hwdata(hwdata), .i_wait(hwait),
            .o_hrdata(rdata[g]), .o_hready(rdy[g]), .o_hresp(resp[g]));
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input bit sel, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic [2:0] size, input bit wr, input logic [31:0] wdata,
                                 input int chk, input logic [31:0] exp);
        beat_t b;
        b.sel = sel; b.trans = trans; b.addr = addr; b.size = size;
        b.wr = wr; b.wdata = wdata; b.chk = chk; b.exp = exp;
        return b;
    endfunction

    function automatic beat_t idle_b();
        return mk(1'b1, 2'd0, $urandom, 3'd2, 1'b0, 32'h0, 0, 32'h0);
    endfunction

    function automatic bit ill(input beat_t b);
        return (b.addr >= 32'h400) || (b.size > 3'd2) || ((b.addr % (32'd1 << b.size)) != 0);
    endfunction

    function automatic void mwrite(input int g, input beat_t b);
        int w, lo;
        w  = int'(b.addr[9:2]);
        lo = int'(b.addr[1:0]);
        for (int k = 0; k < (1 << b.size); k++)
            mm[g][w][8*(lo+k) +: 8] = b.wdata[8*(lo+k) +: 8];
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        int k, off;
        k = $urandom_range(0, 9);
        b.sel   = ($urandom_range(0, 9) != 0);
        b.trans = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k < 6) ? 2'd2 : 2'd3;
        b.size  = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 19) == 0) b.size = 3'($urandom_range(3, 7));
        off = $urandom_range(0, 3);
        if (b.size == 3'd1) off = off & 2;
        else if (b.size != 3'd0) off = 0;
        b.addr = 32'($urandom_range(0, 15) * 4 + off);
        k = $urandom_range(0, 19);
        if (k == 0) b.addr = b.addr + 32'h400;
        else if (k == 1) b.addr = b.addr | 32'h1;
        else if (k == 2) b.addr = 32'hFFFF_FFFC;
        b.wr    = ($urandom_range(0, 1) == 1);
        b.wdata = $urandom;
        b.chk   = 2;
        b.exp   = 32'h0;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        hsel = b.sel; htrans = b.trans; haddr = b.addr; hwrite = b.wr; hsize = b.size;
        hburst = 3'($urandom_range(0, 7));
    endtask

    // Pipelined manager: drives the queue, predicts hready/hresp each cycle and checks read data.
    task automatic run_q();
        beat_t ap, dp;
        bit ap_v, dp_v, adv, r, e;
        int c;
        ap = idle_b(); ap_v = 0; dp = ap; dp_v = 0; adv = 1; c = 0;
        while (1) begin
            @(negedge clk);
            if (adv) begin
                dp = ap; dp_v = ap_v; c = 0;
                if (!dp_v && bq.size() == 0) begin
                    drive(idle_b());
                    hwait = 1'b0;
                    return;
                end
                ap   = (bq.size() > 0) ? bq.pop_front() : idle_b();
                ap_v = ap.sel && ap.trans[1];
                drive(ap);
            end
            hwait = wait_en && ($urandom_range(0, 3) == 0);
            #1;
            e = dp_v && ill(dp);
            r = !dp_v ? 1'b1 : e ? (c >= 1) : ((c >= ws_of[dsel]) && !hwait);
            check("hready", 32'(rdy[dsel]), 32'(r));
            check("hresp", 32'(resp[dsel]), e ? 32'd1 : 32'd0);
            if (rdy[dsel]) begin
                adv = 1;
                hwdata = (dp_v && dp.wr) ? dp.wdata : $urandom;
                if (dp_v && !e) begin
                    if (dp.wr) mwrite(dsel, dp);
                    else if (dp.chk == 1) check("rdata_tbl", rdata[dsel], dp.exp);
                    else if (dp.chk == 2) check("rdata_model", rdata[dsel], mm[dsel][dp.addr[9:2]]);
                end
            end else begin
                adv = 0;
                hwdata = $urandom;
                c++;
                if (c > 50) begin
                    total++; bad++;
                    $display("FAIL stall_bound: hready low %0d cycles, limit 50", c);
                    drive(idle_b());
                    hwait = 1'b0;
                    return;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        drive(idle_b());
        repeat (3) @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check("rst_hready", 32'(rdy[g]), 32'd1);
            check("rst_hresp", 32'(resp[g]), 32'd0);
            check("rst_hrdata", rdata[g], 32'h0);
        end
        rst_n = 1'b1;

        // Directed table on the zero-wait instance.
        dsel = 0; wait_en = 0;
        tbl.push_back(mk(1, 2'd2, 32'h000, 3'd2, 1, 32'h11223344, 0, 32'h0));
        tbl.push_back(mk(1, 2'd3, 32'h004, 3'd2, 1, 32'h55667788, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h000, 3'd2, 0, 32'h0, 1, 32'h11223344));
        tbl.push_back(mk(1, 2'd3, 32'h004, 3'd2, 0, 32'h0, 1, 32'h55667788));
        tbl.push_back(mk(1, 2'd2, 32'h010, 3'd2, 1, 32'hFFFFFFFF, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h011, 3'd0, 1, 32'h0000AA00, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h012, 3'd1, 1, 32'h12340000, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h010, 3'd2, 0, 32'h0, 1, 32'h1234AAFF));
        tbl.push_back(mk(1, 2'd0, 32'h000, 3'd2, 1, 32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h400, 3'd2, 0, 32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h002, 3'd2, 0, 32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h400, 3'd2, 1, 32'h12345678, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h000, 3'd2, 0, 32'h0, 1, 32'h11223344));
        tbl.push_back(mk(1, 2'd2, 32'h020, 3'd2, 1, 32'hCAFEF00D, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h020, 3'd2, 0, 32'h0, 1, 32'hCAFEF00D));
        tbl.push_back(mk(0, 2'd2, 32'h020, 3'd2, 1, 32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd1, 32'h020, 3'd2, 1, 32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h020, 3'd2, 0, 32'h0, 1, 32'hCAFEF00D));
        tbl.push_back(mk(1, 2'd2, 32'h008, 3'd3, 0, 32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h3FC, 3'd2, 1, 32'h01020304, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h3FF, 3'd0, 1, 32'h5A000000, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h3FC, 3'd2, 0, 32'h0, 1, 32'h5A020304));
        tbl.push_back(mk(1, 2'd2, 32'h013, 3'd1, 0, 32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 32'h011, 3'd0, 0, 32'h0, 1, 32'h1234AAFF));
        for (int i = 0; i < tbl.size(); i++) bq.push_back(tbl[i]);
        run_q();

        // Two wait states plus one external wait once the counter has expired.
        dsel = 1;
        @(negedge clk);
        drive(mk(1, 2'd2, 32'h008, 3'd2, 1, 32'h0, 0, 32'h0));
        @(negedge clk);
        drive(idle_b());
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            hwait = (c == 2);
            #1;
            if (rdy[1]) break;
            lows++;
            hwdata = $urandom;
            @(negedge clk);
        end
        hwait = 1'b0;
        hwdata = 32'hDEADBEEF;
        check("ws2_low_cycles", 32'(lows), 32'd3);
        check("ws2_hresp", 32'(resp[1]), 32'd0);
        bq.push_back(mk(1, 2'd2, 32'h008, 3'd2, 0, 32'h0, 1, 32'hDEADBEEF));
        run_q();

        // Reset during a wait cycle must drop the pending write.
        dsel = 2;
        bq.push_back(mk(1, 2'd2, 32'h030, 3'd2, 1, 32'h600DF00D, 0, 32'h0));
        bq.push_back(mk(1, 2'd2, 32'h030, 3'd2, 0, 32'h0, 1, 32'h600DF00D));
        run_q();
        @(negedge clk);
        drive(mk(1, 2'd2, 32'h030, 3'd2, 1, 32'h0, 0, 32'h0));
        @(negedge clk);
        drive(idle_b());
        #1;
        check("ws3_wait1", 32'(rdy[2]), 32'd0);
        hwdata = $urandom;
        @(negedge clk);
        #1;
        check("ws3_wait2", 32'(rdy[2]), 32'd0);
        rst_n = 1'b0;
        hwdata = 32'h0BADBEEF;
        @(negedge clk);
        #1;
        check("midrst_hready", 32'(rdy[2]), 32'd1);
        check("midrst_hresp", 32'(resp[2]), 32'd0);
        check("midrst_hrdata", rdata[2], 32'h0);
        rst_n = 1'b1;
        bq.push_back(mk(1, 2'd2, 32'h030, 3'd2, 0, 32'h0, 1, 32'h600DF00D));
        run_q();

        // Randomized traffic with random external waits on every instance.
        wait_en = 1;
        for (int g = 0; g < 3; g++) begin
            dsel = g;
            for (int w = 0; w < 16; w++)
                bq.push_back(mk(1, 2'd2, 32'(w * 4), 3'd2, 1, $urandom, 0, 32'h0));
            for (int n = 0; n < 150; n++) bq.push_back(rnd_beat());
            for (int w = 0; w < 16; w++)
                bq.push_back(mk(1, 2'd2, 32'(w * 4), 3'd2, 0, 32'h0, 2, 32'h0));
            run_q();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
